bnn_seq_ctrl: RTL and testbench
===============================

Name: bnn_seq_ctrl

Overview:
Frame sequencer for the BNN accelerator. It sits between the external input port and the data/conv/slide/pool/compare pipeline. It owns the handshake with the host, routes beats into weight loading or image streaming, and counts weight words and image rows. It then waits for the classifier result and presents it on the output port. It also flags sequencing errors and pipeline timeouts.

Parameters:
CHANNEL_NUM, 6, number of conv channels (informational; one weight word per channel)
WEIGHT_WORDS, 6, 16-bit weight words per full weight load
IMG_ROWS, 16, 16-bit image rows per frame
DRAIN_TIMEOUT, 255, maximum cycles to wait in DRAIN for result_done (8-bit timer)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mode  in  1  beat type: 1 = weight word, 0 = image row (sampled only on accepted beats)
in_valid  in  1  host beat valid
in_ready  out  1  controller can accept a beat
weight_we  out  1  write strobe to weight store (combinational, = accepted weight beat)
weight_addr  out  $clog2(WEIGHT_WORDS)  index of the weight word being written
row_valid  out  1  accepted image row to conv datapath (combinational)
row_idx  out  $clog2(IMG_ROWS)  row number of the current row_valid
frame_start  out  1  high with row_valid for row 0 only
result_done  in  1  classifier result valid pulse
result_in  in  2  classifier class index
data_out  out  2  registered class result
out_en  out  1  one-cycle result strobe
busy  out  1  state is STREAM, DRAIN or RESULT
err_order  out  1  sticky: image row received before a complete weight load
err_timeout  out  1  sticky: DRAIN timer expired

Behaviour:
- accept = in_valid & in_ready. in_ready = 1 in IDLE, LOAD_W, READY and STREAM; 0 in DRAIN and RESULT.
- Reset (async, any state): state=IDLE, all counters 0, weights_ok=0, data_out=0, out_en=0, err_order=0, err_timeout=0. Combinational outputs are 0 apart from in_ready=1.
- IDLE:
  - accept & mode=1: weight_we=1, weight_addr=0, wcnt<=1, go LOAD_W (go READY if WEIGHT_WORDS=1).
  - accept & mode=0: beat is discarded, err_order<=1, stay in IDLE.
- LOAD_W:
  - Each accept writes weight_addr=wcnt regardless of mode, then wcnt++.
  - On word WEIGHT_WORDS-1: wcnt<=0, weights_ok<=1, go READY.
- READY:
  - accept & mode=1: restart the weight load at addr 0, exactly as in IDLE. weights_ok stays 1 until the reload completes.
  - accept & mode=0: row_valid=1, row_idx=0, frame_start=1, rcnt<=1, go STREAM.
- STREAM:
  - Each accept is an image row regardless of mode. row_valid=1, row_idx=rcnt, rcnt++.
  - Row IMG_ROWS-1: rcnt<=0, timer<=0, go DRAIN.
  - in_valid low inserts gaps. No timeout applies in STREAM.
- DRAIN:
  - timer++ each cycle.
  - result_done=1: data_out<=result_in, go RESULT.
  - timer==DRAIN_TIMEOUT without result_done: err_timeout<=1, go READY, no out_en.
  - result_done in the same cycle as expiry: the result wins and no error is flagged.
- RESULT: out_en=1 for exactly this cycle. data_out holds until the next result. Go READY next cycle.
- Latency: row_valid/weight_we in the same cycle as accept. out_en asserts 1 cycle after result_done. Next frame row accepted at the earliest 2 cycles after result_done.
- result_done outside DRAIN is ignored.
- Error flags clear only on reset.

Optional Feature:
BNN_SEQ_PERF_EN:
- Defined: adds output frame_cnt [15:0]. It increments on each out_en, saturates at 16'hFFFF, and resets to 0. It also adds output timeout_cnt [7:0], which increments on each timeout and saturates at 8'hFF.
- Undefined: both ports and their counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset, then 6 beats mode=1 data 0x0001..0x0006 back-to-back -> weight_we on 6 cycles with weight_addr 0..5; state READY; in_ready=1.
- After weight load, 16 rows mode=0 with in_valid toggling 1/0 -> row_valid 16 times, row_idx 0..15, frame_start only on row 0; in_ready=0 after row 15.
- In DRAIN, drive result_done=1 with result_in=2'b10 at 10 cycles -> next cycle out_en=1 for one cycle, data_out=2'b10 held; next frame accepted.
- Image row before any weights (mode=0 in IDLE) -> no row_valid, err_order=1 and sticky; a following weight load proceeds normally.
- Full frame with no result_done -> after 255 DRAIN cycles err_timeout=1, state READY, out_en never asserted; result_done arriving later is ignored.
- Assert rst_n=0 at row 7 of STREAM -> all outputs reset immediately; an image row after release sets err_order=1 (weights_ok cleared).

Source files
------------

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl -- frame sequencer for the BNN accelerator.
//
// Sits between the host input port and the conv/slide/pool/compare pipeline.
// Host beats are either weight words (loaded into the weight store) or image
// rows (streamed to the conv datapath). Once a full frame of rows has gone
// out, the controller waits in DRAIN for the classifier result. It then
// presents the result for one cycle and returns to READY for the next frame.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mode, in_valid, in_ready   host beat handshake (mode 1 = weight, 0 = row)
//   weight_we, weight_addr     weight store write strobe / word index
//   row_valid, row_idx         accepted image row to the conv datapath
//   frame_start                marks row 0 of a frame
//   result_done, result_in     classifier result pulse / class index
//   data_out, out_en           registered class result / one-cycle strobe
//   busy                       frame in flight (STREAM, DRAIN or RESULT)
//   err_order, err_timeout     sticky sequencing / drain-timeout errors
//
// Optional build macro BNN_SEQ_PERF_EN adds the frame_cnt and timeout_cnt
// saturating performance counters.

module bnn_seq_ctrl #(
    parameter int CHANNEL_NUM   = 6,
    parameter int WEIGHT_WORDS  = 6,
    parameter int IMG_ROWS      = 16,
    parameter int DRAIN_TIMEOUT = 255,
    localparam int WA = (WEIGHT_WORDS > 1) ? $clog2(WEIGHT_WORDS) : 1,
    localparam int RA = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          weight_we,
    output logic [WA-1:0] weight_addr,
    output logic          row_valid,
    output logic [RA-1:0] row_idx,
    output logic          frame_start,
    input  logic          result_done,
    input  logic [1:0]    result_in,
    output logic [1:0]    data_out,
    output logic          out_en,
    output logic          busy,
    output logic          err_order,
    output logic          err_timeout
`ifdef BNN_SEQ_PERF_EN
    ,
    output logic [15:0]   frame_cnt,
    output logic [7:0]    timeout_cnt
`endif
);

    // One weight word per conv channel; reject degenerate configurations.
    if (CHANNEL_NUM < 1 || WEIGHT_WORDS < 1 || IMG_ROWS < 1) begin : g_bad_cfg
        $error("bnn_seq_ctrl: parameters must be >= 1");
    end

    localparam logic [WA-1:0] W_LAST  = WA'(WEIGHT_WORDS - 1);
    localparam logic [WA-1:0] W_FIRST = (WEIGHT_WORDS == 1) ? '0 : WA'(1);
    localparam logic [RA-1:0] R_LAST  = RA'(IMG_ROWS - 1);
    localparam logic [RA-1:0] R_FIRST = (IMG_ROWS == 1) ? '0 : RA'(1);
    localparam logic [7:0]    T_MAX   = 8'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_W, S_READY, S_STREAM, S_DRAIN, S_RESULT
    } state_t;

    state_t        state, state_nxt;
    logic [WA-1:0] wcnt;
    logic [RA-1:0] rcnt;
    logic [7:0]    timer;
    logic          weights_ok;
    logic          accept, w_last, r_last, t_exp;

    assign in_ready = (state != S_DRAIN) && (state != S_RESULT);
    assign accept   = in_valid & in_ready;
    assign w_last   = (wcnt == W_LAST);
    assign r_last   = (rcnt == R_LAST);
    assign t_exp    = (timer == T_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:
                if (accept && mode)
                    state_nxt = (WEIGHT_WORDS == 1) ? S_READY : S_LOAD_W;
            S_LOAD_W:
                if (accept && w_last) state_nxt = S_READY;
            S_READY:
                if (accept) begin
                    if (mode) state_nxt = (WEIGHT_WORDS == 1) ? S_READY : S_LOAD_W;
                    else      state_nxt = (IMG_ROWS == 1) ? S_DRAIN : S_STREAM;
                end
            S_STREAM:
                if (accept && r_last) state_nxt = S_DRAIN;
            S_DRAIN:
                // A result arriving on the expiry cycle still wins.
                if (result_done) state_nxt = S_RESULT;
                else if (t_exp)  state_nxt = S_READY;
            S_RESULT:
                state_nxt = S_READY;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    // Output logic (in_ready is driven above so accept has no comb loop)
    always_comb begin
        weight_we   = 1'b0;
        weight_addr = '0;
        row_valid   = 1'b0;
        row_idx     = '0;
        frame_start = 1'b0;
        out_en      = (state == S_RESULT);
        busy        = (state == S_STREAM) || (state == S_DRAIN) || (state == S_RESULT);
        case (state)
            S_IDLE:
                weight_we = accept & mode;
            S_LOAD_W: begin
                weight_we   = accept;
                weight_addr = accept ? wcnt : '0;
            end
            S_READY: begin
                weight_we   = accept & mode;
                row_valid   = accept & ~mode;
                frame_start = accept & ~mode;
            end
            S_STREAM: begin
                row_valid = accept;
                row_idx   = accept ? rcnt : '0;
            end
            default: ;
        endcase
    end

    // Counters, result register and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt        <= '0;
            rcnt        <= '0;
            timer       <= '0;
            weights_ok  <= 1'b0;
            data_out    <= '0;
            err_order   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE:
                    if (accept) begin
                        if (mode) begin
                            wcnt <= W_FIRST;
                            if (WEIGHT_WORDS == 1) weights_ok <= 1'b1;
                        end else if (!weights_ok) begin
                            err_order <= 1'b1;   // row is dropped
                        end
                    end
                S_LOAD_W:
                    if (accept) begin
                        if (w_last) begin
                            wcnt       <= '0;
                            weights_ok <= 1'b1;
                        end else begin
                            wcnt <= wcnt + WA'(1);
                        end
                    end
                S_READY:
                    if (accept) begin
                        if (mode) begin
                            // Reload: old weights_ok stays set meanwhile.
                            wcnt <= W_FIRST;
                            if (WEIGHT_WORDS == 1) weights_ok <= 1'b1;
                        end else begin
                            rcnt <= R_FIRST;
                            if (IMG_ROWS == 1) timer <= '0;
                        end
                    end
                S_STREAM:
                    if (accept) begin
                        if (r_last) begin
                            rcnt  <= '0;
                            timer <= '0;
                        end else begin
                            rcnt <= rcnt + RA'(1);
                        end
                    end
                S_DRAIN: begin
                    timer <= timer + 8'd1;
                    if (result_done)  data_out    <= result_in;
                    else if (t_exp)   err_timeout <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BNN_SEQ_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            if (out_en && frame_cnt != 16'hFFFF)
                frame_cnt <= frame_cnt + 16'd1;
            if (state == S_DRAIN && !result_done && t_exp && timeout_cnt != 8'hFF)
                timeout_cnt <= timeout_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Self-checking bench for bnn_seq_ctrl: directed test-plan sequences followed
// by randomized host/classifier traffic, all compared every cycle against a
// transaction-level reference model of the sequencer.
module tb_bnn_seq_ctrl;

    localparam int WW   = 6;
    localparam int ROWS = 16;
    localparam int TO   = 255;

    localparam int P_IDLE = 0, P_LOAD = 1, P_READY = 2, P_STREAM = 3, P_DRAIN = 4, P_RESULT = 5;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       mode = 1'b0, in_valid = 1'b0, result_done = 1'b0;
    logic [1:0] result_in = 2'b00;
    logic       in_ready, weight_we, row_valid, frame_start, out_en, busy;
    logic       err_order, err_timeout;
    logic [2:0] weight_addr;
    logic [3:0] row_idx;
    logic [1:0] data_out;
`ifdef BNN_SEQ_PERF_EN
    logic [15:0] frame_cnt;
    logic [7:0]  timeout_cnt;
`endif

    always #5 clk = ~clk;

    bnn_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .weight_we(weight_we), .weight_addr(weight_addr),
        .row_valid(row_valid), .row_idx(row_idx), .frame_start(frame_start),
        .result_done(result_done), .result_in(result_in),
        .data_out(data_out), .out_en(out_en), .busy(busy),
        .err_order(err_order), .err_timeout(err_timeout)
`ifdef BNN_SEQ_PERF_EN
        , .frame_cnt(frame_cnt), .timeout_cnt(timeout_cnt)
`endif
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: which phase the frame is in, how many weight words and
    // rows have been taken, and how long we have waited for the classifier.
    int         ph, words, rows, waited, frames, touts;
    logic [1:0] m_dout;
    bit         m_eo, m_et;

    task automatic m_reset();
        ph = P_IDLE; words = 0; rows = 0; waited = 0; frames = 0; touts = 0;
        m_dout = 2'b00; m_eo = 0; m_et = 0;
    endtask

    function automatic bit m_ready();
        return ph == P_IDLE || ph == P_LOAD || ph == P_READY || ph == P_STREAM;
    endfunction

    task automatic check_outputs();
        bit acc, we, rv, fs;
        int wa, ridx;
        acc  = in_valid && m_ready();
        we   = acc && (ph == P_LOAD || ((ph == P_IDLE || ph == P_READY) && mode));
        wa   = (we && ph == P_LOAD) ? words : 0;
        rv   = acc && (ph == P_STREAM || (ph == P_READY && !mode));
        ridx = (rv && ph == P_STREAM) ? rows : 0;
        fs   = acc && ph == P_READY && !mode;
        chk("in_ready",    in_ready,    m_ready());
        chk("weight_we",   weight_we,   we);
        chk("weight_addr", weight_addr, wa);
        chk("row_valid",   row_valid,   rv);
        chk("row_idx",     row_idx,     ridx);
        chk("frame_start", frame_start, fs);
        chk("out_en",      out_en,      ph == P_RESULT);
        chk("busy",        busy,        ph == P_STREAM || ph == P_DRAIN || ph == P_RESULT);
        chk("data_out",    data_out,    m_dout);
        chk("err_order",   err_order,   m_eo);
        chk("err_timeout", err_timeout, m_et);
`ifdef BNN_SEQ_PERF_EN
        chk("frame_cnt",   frame_cnt,   frames);
        chk("timeout_cnt", timeout_cnt, touts);
`endif
    endtask

    task automatic m_step();
        bit acc;
        acc = in_valid && m_ready();
        case (ph)
            P_IDLE:
                if (acc) begin
                    if (mode) begin words = 1; ph = (WW == 1) ? P_READY : P_LOAD; end
                    else m_eo = 1;
                end
            P_LOAD:
                if (acc) begin
                    words++;
                    if (words == WW) begin words = 0; ph = P_READY; end
                end
            P_READY:
                if (acc) begin
                    if (mode) begin words = 1; ph = P_LOAD; end
                    else begin rows = 1; ph = P_STREAM; end
                end
            P_STREAM:
                if (acc) begin
                    rows++;
                    if (rows == ROWS) begin rows = 0; waited = 0; ph = P_DRAIN; end
                end
            P_DRAIN:
                if (result_done) begin m_dout = result_in; ph = P_RESULT; end
                else if (waited == TO) begin
                    m_et = 1; ph = P_READY;
                    if (touts < 255) touts++;
                end
                else waited++;
            P_RESULT: begin
                ph = P_READY;
                if (frames < 65535) frames++;
            end
            default: ph = P_IDLE;
        endcase
    endtask

    task automatic step(input bit iv, input bit md, input bit rd, input logic [1:0] ri);
        @(negedge clk);
        in_valid = iv; mode = md; result_done = rd; result_in = ri;
        #1;
        check_outputs();
        @(posedge clk);
        m_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 0; result_done = 0; rst_n = 0;
        m_reset();
        #1 check_outputs();
        @(negedge clk);
        #1 check_outputs();
        rst_n = 1;
    endtask

    task automatic load_weights();
        for (int i = 0; i < WW; i++) step(1, 1, 0, 2'b00);
    endtask

    initial begin
        int rdiv;
        m_reset();
        repeat (2) begin @(negedge clk); #1 check_outputs(); end
        rst_n = 1;

        // Image row before any weights: dropped, sticky err_order.
        step(1, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);
        // Weight load, back-to-back.
        load_weights();
        step(0, 0, 0, 2'b00);
        // Frame with gapped rows.
        for (int i = 0; i < 2 * ROWS; i++) step(i % 2 == 0, 0, 0, 2'b00);
        // Result after 10 drain cycles, then strobe and idle.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 2'b00);
        step(0, 0, 1, 2'b10);
        step(0, 0, 0, 2'b01);
        step(0, 0, 0, 2'b00);
        // Next frame, no result: timeout; a late result is ignored.
        for (int i = 0; i < ROWS; i++) step(1, 0, 0, 2'b00);
        for (int i = 0; i < TO + 3; i++) step(0, 0, 0, 2'b00);
        step(0, 0, 1, 2'b11);
        step(0, 0, 0, 2'b00);
        // Reload weights from READY, then a frame cut by reset at row 7.
        load_weights();
        for (int i = 0; i < 7; i++) step(1, 0, 0, 2'b00);
        do_reset();
        step(1, 0, 0, 2'b00);
        step(0, 0, 0, 2'b00);

        // Randomized traffic with varying classifier latency.
        for (int blk = 0; blk < 4; blk++) begin
            rdiv = (blk == 0) ? 6 : (blk == 1) ? 40 : (blk == 2) ? 2000 : 12;
            for (int i = 0; i < 1000; i++)
                step(($urandom % 4) != 0, ($urandom % 8) == 0,
                     ($urandom % rdiv) == 0, 2'($urandom));
            if (blk == 1) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
